crc8_frame_tx: RTL

//  Serial frame transmitter placed directly upstream of crc8 in the link TX path.

---
 rtl/crc8_frame_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/crc8_frame_tx.sv
// Serial frame transmitter: shifts bytes out MSB-first at the bit_en rate and
// optionally appends the 8-bit CRC held by an external crc8 block, which this
// module clears, feeds and reads back.
module crc8_frame_tx #(
  parameter bit CRC_EN   = 1'b1,
  parameter bit IDLE_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_bit,
  output logic       tx_active,
  output logic       tx_frame_end,
  output logic       crc_clr,
  output logic       crc_shift,
  output logic       crc_in,
  input  logic [7:0] crc
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP, S_CRC} state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lst_q, lst_d;
  logic       tx_bit_q, tx_bit_d;
  logic       active_q, active_d;
  logic       fe_q, fe_d;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      lst_q    <= 1'b0;
      tx_bit_q <= IDLE_BIT;
      active_q <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      lst_q    <= lst_d;
      tx_bit_q <= tx_bit_d;
      active_q <= active_d;
      fe_q     <= fe_d;
    end
  end

  // Next-state, handshake and crc8 control. crc8 samples crc_in on the same
  // edge that registers the data bit, so its value is final once we reach S_CRC.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    lst_d     = lst_q;
    tx_bit_d  = tx_bit_q;
    active_d  = active_q;
    fe_d      = 1'b0;
    s_ready   = 1'b0;
    crc_clr   = 1'b0;
    crc_shift = 1'b0;
    crc_in    = 1'b0;

    case (state_q)
      S_IDLE: begin
        s_ready = 1'b1;
        crc_clr = 1'b1;
        // Once the final bit has been held for its bit time, fall back to idle level.
        if (bit_en) tx_bit_d = IDLE_BIT;
        if (s_valid) begin
          sr_d     = s_data;
          lst_d    = s_last;
          cnt_d    = 3'd0;
          active_d = 1'b1;
          state_d  = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_en) begin
          crc_shift = 1'b1;
          crc_in    = sr_q[7];
          tx_bit_d  = sr_q[7];
          sr_d      = {sr_q[6:0], 1'b0};
          cnt_d     = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (lst_q) begin
              if (CRC_EN) begin
                state_d = S_CRC;
              end else begin
                fe_d     = 1'b1;
                active_d = 1'b0;
                state_d  = S_IDLE;
              end
            end else begin
              // Next byte may load on the same strobe as the last bit: no gap.
              s_ready = 1'b1;
              if (s_valid) begin
                sr_d  = s_data;
                lst_d = s_last;
                cnt_d = 3'd0;
              end else begin
                state_d = S_GAP;
              end
            end
          end
        end
      end

      S_GAP: begin
        // Upstream underrun: pad with idle level, crc8 holds.
        s_ready = 1'b1;
        if (bit_en) tx_bit_d = IDLE_BIT;
        if (s_valid) begin
          sr_d    = s_data;
          lst_d   = s_last;
          cnt_d   = 3'd0;
          state_d = S_DATA;
        end
      end

      S_CRC: begin
        if (bit_en) begin
          tx_bit_d = crc[3'd7 - cnt_q];
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            fe_d     = 1'b1;
            active_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign tx_bit       = tx_bit_q;
  assign tx_active    = active_q;
  assign tx_frame_end = fe_q;

endmodule
